// File: rtl/int_source_ctrl.sv
// Interrupt source controller: per-line sync/edge detect, pending/enable, single-level claim/complete.
// Optional level-triggered sources via `define INTSRC_LEVEL_EN (adds TRIGGER register at index 4).
module int_source_ctrl #(
   parameter int NSRC  = 4,
   parameter int ADR_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NSRC-1:0]  irq_in,
   input  logic             io_we,
   input  logic             io_re,
   input  logic [ADR_W-1:0] io_adr,
   input  logic [31:0]      io_wdata,
   output logic [31:0]      io_rdata,
   output logic             interrupt_0,
   output logic             interrupt_clear
);

   localparam logic [ADR_W-1:0] A_PEND  = ADR_W'(0);
   localparam logic [ADR_W-1:0] A_EN    = ADR_W'(1);
   localparam logic [ADR_W-1:0] A_CLAIM = ADR_W'(2);
   localparam logic [ADR_W-1:0] A_COMP  = ADR_W'(3);
`ifdef INTSRC_LEVEL_EN
   localparam logic [ADR_W-1:0] A_TRIG  = ADR_W'(4);
`endif

   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   state_e          state_q, state_d;
   logic [NSRC-1:0] s1_q, s2_q, s3_q;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] en_q, en_d;
   logic [4:0]      svc_q, svc_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            irq0_q, irq0_d;
   logic            clr_q, clr_d;
`ifdef INTSRC_LEVEL_EN
   logic [NSRC-1:0] trig_q, trig_d;
`endif

   logic [NSRC-1:0] edge_w;
   logic [4:0]      claim_id;
   logic            claim_go;
   logic            busy;
   logic [31:0]     rd_val;
   logic            unused_wdata;

   assign unused_wdata = ^io_wdata;
   assign edge_w       = s2_q & ~s3_q;
   assign busy         = (state_q == ST_BUSY);

   // Downward scan so the lowest claimable index is the last one written.
   always_comb begin
      claim_id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pend_q[i] && en_q[i]) claim_id = 5'(i + 1);
      end
      if (busy) claim_id = '0;
   end

   assign claim_go = io_re && (io_adr == A_CLAIM) && (claim_id != 5'd0);

   always_comb begin
      rd_val = '0;
      case (io_adr)
         A_PEND:  rd_val[NSRC-1:0] = pend_q;
         A_EN:    rd_val[NSRC-1:0] = en_q;
         A_CLAIM: rd_val[4:0]      = claim_id;
         A_COMP:  rd_val           = {busy, 26'b0, svc_q};
`ifdef INTSRC_LEVEL_EN
         A_TRIG:  rd_val[NSRC-1:0] = trig_q;
`endif
         default: rd_val = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      svc_d   = svc_q;
      en_d    = en_q;
      pend_d  = pend_q;
      rdata_d = io_re ? rd_val : rdata_q;
      irq0_d  = |(pend_q & en_q) & ~busy;
      clr_d   = claim_go;
`ifdef INTSRC_LEVEL_EN
      trig_d  = trig_q;
`endif

      if (io_we && io_adr == A_PEND) pend_d = pend_d & ~io_wdata[NSRC-1:0];
      for (int i = 0; i < NSRC; i++) begin
         if (claim_go && claim_id == 5'(i + 1)) pend_d[i] = 1'b0;
      end
      // A new edge beats any clear in the same cycle.
      pend_d = pend_d | edge_w;
`ifdef INTSRC_LEVEL_EN
      pend_d = (pend_d & ~trig_q) | (s2_q & trig_q);
      if (io_we && io_adr == A_TRIG) trig_d = io_wdata[NSRC-1:0];
`endif

      if (io_we && io_adr == A_EN) en_d = io_wdata[NSRC-1:0];

      case (state_q)
         ST_IDLE: begin
            if (claim_go) begin
               state_d = ST_BUSY;
               svc_d   = claim_id;
            end
         end
         ST_BUSY: begin
            if (io_we && io_adr == A_COMP && io_wdata[4:0] == svc_q) begin
               state_d = ST_IDLE;
               svc_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         pend_q  <= '0;
         en_q    <= '0;
         svc_q   <= '0;
         rdata_q <= '0;
         irq0_q  <= 1'b0;
         clr_q   <= 1'b0;
`ifdef INTSRC_LEVEL_EN
         trig_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         s1_q    <= irq_in;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         pend_q  <= pend_d;
         en_q    <= en_d;
         svc_q   <= svc_d;
         rdata_q <= rdata_d;
         irq0_q  <= irq0_d;
         clr_q   <= clr_d;
`ifdef INTSRC_LEVEL_EN
         trig_q  <= trig_d;
`endif
      end
   end

   assign io_rdata        = rdata_q;
   assign interrupt_0     = irq0_q;
   assign interrupt_clear = clr_q;

endmodule
